// File: rtl/tomasulo_rs_array_if.sv
// Bus bundle for the reservation-station array: issue, CDB, dispatch,
// clear, flush and occupancy. The RS array connects to the slave modport.
// The environment that drives issue/CDB/clear and receives dispatch
// connects to the master modport.
interface tomasulo_rs_array_if #(
    parameter int NUM_ENTRIES = 4,
    parameter int TAG_WIDTH   = 4,
    parameter int DATA_WIDTH  = 32
);
    localparam int OCC_WIDTH = $clog2(NUM_ENTRIES + 1);

    // Handshakes: an issue transfers on a cycle where issue_valid && issue_ready.
    // A dispatch transfers on a cycle where dispatch_valid && dispatch_ack.
    // Valid never depends on ready/ack. issue_ready may depend on the issue
    // payload through CDB tag conflicts.
    // Payloads are meaningful only while their valid is high. dispatch_* reads
    // zero otherwise.
    logic                   issue_valid;
    logic                   issue_ready;
    logic [2:0]             issue_op;
    logic [DATA_WIDTH-1:0]  issue_vj;
    logic [DATA_WIDTH-1:0]  issue_vk;
    logic [TAG_WIDTH-1:0]   issue_qj;
    logic [TAG_WIDTH-1:0]   issue_qk;
    logic [DATA_WIDTH-1:0]  issue_addr;
    logic [TAG_WIDTH-1:0]   issue_tag;

    logic                   cdb_valid;
    logic [TAG_WIDTH-1:0]   cdb_tag;
    logic [DATA_WIDTH-1:0]  cdb_data;

    logic                   dispatch_valid;
    logic [2:0]             dispatch_op;
    logic [DATA_WIDTH-1:0]  dispatch_vj;
    logic [DATA_WIDTH-1:0]  dispatch_vk;
    logic [DATA_WIDTH-1:0]  dispatch_addr;
    logic [TAG_WIDTH-1:0]   dispatch_tag;
    logic                   dispatch_ack;

    logic                   clear_valid;
    logic [TAG_WIDTH-1:0]   clear_tag;

    logic                   flush;
    logic [OCC_WIDTH-1:0]   occupancy;

    modport master (
        output issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk, issue_addr,
        input  issue_ready, issue_tag,
        output cdb_valid, cdb_tag, cdb_data,
        input  dispatch_valid, dispatch_op, dispatch_vj, dispatch_vk, dispatch_addr, dispatch_tag,
        output dispatch_ack,
        output clear_valid, clear_tag,
        output flush,
        input  occupancy
    );

    modport slave (
        input  issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk, issue_addr,
        output issue_ready, issue_tag,
        input  cdb_valid, cdb_tag, cdb_data,
        output dispatch_valid, dispatch_op, dispatch_vj, dispatch_vk, dispatch_addr, dispatch_tag,
        input  dispatch_ack,
        input  clear_valid, clear_tag,
        input  flush,
        output occupancy
    );
endinterface

// File: rtl/tomasulo_rs_array.sv
// Tomasulo reservation-station array. Each entry is FREE, WAITING, READY or EXEC.
// Issue allocates the lowest-index free entry. A CDB broadcast wakes waiting operands.
// The oldest READY entry is offered for dispatch, and a clear of an EXEC tag frees its entry.
// Optional macro TOMASULO_RS_ISSUE_BYPASS_EN: an issuing operand can capture a
// same-cycle CDB result. Without the macro, issue stalls on that conflict instead.
module tomasulo_rs_array #(
    parameter int NUM_ENTRIES = 4,
    parameter int TAG_WIDTH   = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int BASE_TAG    = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    tomasulo_rs_array_if.slave       bus,
    output logic [2*NUM_ENTRIES-1:0] state_dbg
);
    localparam int IDX_WIDTH = $clog2(NUM_ENTRIES);
    localparam int OCC_WIDTH = $clog2(NUM_ENTRIES + 1);

    typedef enum logic [1:0] {
        ST_FREE    = 2'd0,
        ST_WAITING = 2'd1,
        ST_READY   = 2'd2,
        ST_EXEC    = 2'd3
    } entry_state_e;

    entry_state_e           state_q [NUM_ENTRIES];
    entry_state_e           state_d [NUM_ENTRIES];
    logic [2:0]             op_q    [NUM_ENTRIES];
    logic [2:0]             op_d    [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]  vj_q    [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]  vj_d    [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]  vk_q    [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]  vk_d    [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]  addr_q  [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]  addr_d  [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]   qj_q    [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]   qj_d    [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]   qk_q    [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]   qk_d    [NUM_ENTRIES];
    // older_q[a][b] set means entry a was issued before entry b
    logic [NUM_ENTRIES-1:0] older_q [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] older_d [NUM_ENTRIES];

    logic                   free_found;
    logic [IDX_WIDTH-1:0]   free_idx;
    logic                   sel_found;
    logic [IDX_WIDTH-1:0]   sel_idx;
    logic                   sel_blocked;
    logic [OCC_WIDTH-1:0]   occ;
    logic                   cdb_hit;
    logic                   issue_fire;
    logic                   dispatch_fire;
    logic [DATA_WIDTH-1:0]  in_vj;
    logic [DATA_WIDTH-1:0]  in_vk;
    logic [TAG_WIDTH-1:0]   in_qj;
    logic [TAG_WIDTH-1:0]   in_qk;

    // Lowest free entry, oldest READY entry and occupancy, all from registered state
    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        sel_found   = 1'b0;
        sel_idx     = '0;
        sel_blocked = 1'b0;
        occ         = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (state_q[i] == ST_FREE) begin
                free_found = 1'b1;
                free_idx   = IDX_WIDTH'(i);
            end
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (state_q[i] != ST_FREE) occ = occ + OCC_WIDTH'(1);
            if (state_q[i] == ST_READY) begin
                sel_blocked = 1'b0;
                for (int j = 0; j < NUM_ENTRIES; j++) begin
                    if (j != i && state_q[j] == ST_READY && older_q[j][i]) sel_blocked = 1'b1;
                end
                if (!sel_blocked) begin
                    sel_found = 1'b1;
                    sel_idx   = IDX_WIDTH'(i);
                end
            end
        end
    end

    // Resolve issuing operands against the CDB and form both handshakes
    always_comb begin
        cdb_hit = bus.cdb_valid && (bus.cdb_tag != '0);
        in_vj   = bus.issue_vj;
        in_vk   = bus.issue_vk;
        in_qj   = bus.issue_qj;
        in_qk   = bus.issue_qk;
`ifdef TOMASULO_RS_ISSUE_BYPASS_EN
        if (cdb_hit && bus.issue_qj == bus.cdb_tag) begin
            in_vj = bus.cdb_data;
            in_qj = '0;
        end
        if (cdb_hit && bus.issue_qk == bus.cdb_tag) begin
            in_vk = bus.cdb_data;
            in_qk = '0;
        end
        bus.issue_ready = free_found;
`else
        // The broadcast would be missed by an entry loading this cycle, so hold off
        bus.issue_ready = free_found &&
                          !(cdb_hit && (bus.issue_qj == bus.cdb_tag || bus.issue_qk == bus.cdb_tag));
`endif
        issue_fire    = bus.issue_valid && bus.issue_ready;
        dispatch_fire = sel_found && bus.dispatch_ack;
    end

    // Output drive: allocation tag, dispatch payload (zero when idle), occupancy
    always_comb begin
        bus.issue_tag      = free_found ? TAG_WIDTH'(BASE_TAG) + TAG_WIDTH'(free_idx) : '0;
        bus.dispatch_valid = sel_found;
        bus.dispatch_op    = sel_found ? op_q[sel_idx]   : '0;
        bus.dispatch_vj    = sel_found ? vj_q[sel_idx]   : '0;
        bus.dispatch_vk    = sel_found ? vk_q[sel_idx]   : '0;
        bus.dispatch_addr  = sel_found ? addr_q[sel_idx] : '0;
        bus.dispatch_tag   = sel_found ? TAG_WIDTH'(BASE_TAG) + TAG_WIDTH'(sel_idx) : '0;
        bus.occupancy      = occ;
    end

    // Per-entry next state: wakeup, dispatch, clear and issue; flush overrides all
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            state_d[i] = state_q[i];
            op_d[i]    = op_q[i];
            vj_d[i]    = vj_q[i];
            vk_d[i]    = vk_q[i];
            addr_d[i]  = addr_q[i];
            qj_d[i]    = qj_q[i];
            qk_d[i]    = qk_q[i];
            older_d[i] = older_q[i];
        end
        if (bus.flush) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                state_d[i] = ST_FREE;
                op_d[i]    = '0;
                vj_d[i]    = '0;
                vk_d[i]    = '0;
                addr_d[i]  = '0;
                qj_d[i]    = '0;
                qk_d[i]    = '0;
                older_d[i] = '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (state_q[i] == ST_WAITING && cdb_hit) begin
                    if (qj_q[i] == bus.cdb_tag) begin
                        vj_d[i] = bus.cdb_data;
                        qj_d[i] = '0;
                    end
                    if (qk_q[i] == bus.cdb_tag) begin
                        vk_d[i] = bus.cdb_data;
                        qk_d[i] = '0;
                    end
                    // READY only from the next cycle, so no same-cycle wakeup-to-dispatch
                    if (qj_d[i] == '0 && qk_d[i] == '0) state_d[i] = ST_READY;
                end
                if (dispatch_fire && sel_idx == IDX_WIDTH'(i)) state_d[i] = ST_EXEC;
                if (bus.clear_valid && state_q[i] == ST_EXEC &&
                    bus.clear_tag == TAG_WIDTH'(BASE_TAG + i)) state_d[i] = ST_FREE;
                if (issue_fire && free_idx == IDX_WIDTH'(i)) begin
                    op_d[i]    = bus.issue_op;
                    vj_d[i]    = in_vj;
                    vk_d[i]    = in_vk;
                    addr_d[i]  = bus.issue_addr;
                    qj_d[i]    = in_qj;
                    qk_d[i]    = in_qk;
                    state_d[i] = (in_qj == '0 && in_qk == '0) ? ST_READY : ST_WAITING;
                    older_d[i] = '0;
                end
            end
            // Every other entry now counts as older than the one just issued
            if (issue_fire) begin
                for (int j = 0; j < NUM_ENTRIES; j++) begin
                    if (IDX_WIDTH'(j) != free_idx) older_d[j][free_idx] = 1'b1;
                end
            end
        end
    end

    // Entry state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                state_q[i] <= ST_FREE;
                op_q[i]    <= '0;
                vj_q[i]    <= '0;
                vk_q[i]    <= '0;
                addr_q[i]  <= '0;
                qj_q[i]    <= '0;
                qk_q[i]    <= '0;
                older_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                state_q[i] <= state_d[i];
                op_q[i]    <= op_d[i];
                vj_q[i]    <= vj_d[i];
                vk_q[i]    <= vk_d[i];
                addr_q[i]  <= addr_d[i];
                qj_q[i]    <= qj_d[i];
                qk_q[i]    <= qk_d[i];
                older_q[i] <= older_d[i];
            end
        end
    end

    // Per-entry state, two bits per entry, for observation
    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_dbg
        assign state_dbg[2*g +: 2] = state_q[g];
    end
endmodule

// File: tb/tb_tomasulo_rs_array.sv
// Testbench for tomasulo_rs_array: directed scenarios plus randomized traffic,
// checked against an issue-ordered behavioural model through a scoreboard.
module tb_tomasulo_rs_array;
  localparam int NE   = 4;
  localparam int TW   = 4;
  localparam int DW   = 32;
  localparam int BASE = 1;
  localparam int OW   = $clog2(NE + 1);
  localparam int PW   = 3 + 3 * DW + TW;

  typedef struct packed {
    logic          issue_valid;
    logic [2:0]    op;
    logic [DW-1:0] vj;
    logic [DW-1:0] vk;
    logic [DW-1:0] addr;
    logic [TW-1:0] qj;
    logic [TW-1:0] qk;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [DW-1:0] cdb_data;
    logic          ack;
    logic          clear_valid;
    logic [TW-1:0] clear_tag;
    logic          flush;
  } stim_t;

  typedef struct packed {
    logic          ready;
    logic          has_free;
    logic [TW-1:0] tag;
    logic [OW-1:0] occ;
    logic          dv;
    logic [NE-1:0] busy;
    logic [PW-1:0] pkt;
  } status_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2*NE-1:0] state_dbg;
  always #5 clk = ~clk;

  tomasulo_rs_array_if #(.NUM_ENTRIES(NE), .TAG_WIDTH(TW), .DATA_WIDTH(DW)) bus ();

  tomasulo_rs_array #(
    .NUM_ENTRIES(NE), .TAG_WIDTH(TW), .DATA_WIDTH(DW), .BASE_TAG(BASE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave),
    .state_dbg(state_dbg)
  );

  // scoreboard state
  logic [PW-1:0] exp_q[$];
  status_t       stat_q[$];
  int            n_checks = 0;
  int            n_errors = 0;

  // reference model: entries plus the list of live entries in issue order
  logic          m_busy [NE];
  logic          m_disp [NE];
  logic [2:0]    m_op   [NE];
  logic [DW-1:0] m_vj   [NE];
  logic [DW-1:0] m_vk   [NE];
  logic [DW-1:0] m_addr [NE];
  logic [TW-1:0] m_qj   [NE];
  logic [TW-1:0] m_qk   [NE];
  int            m_order[$];

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] pkt_of(input int e);
    return {m_op[e], m_vj[e], m_vk[e], m_addr[e], TW'(BASE + e)};
  endfunction

  function automatic stim_t idle_s();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m_busy[i] = 1'b0; m_disp[i] = 1'b0; m_op[i] = '0;
      m_vj[i] = '0; m_vk[i] = '0; m_addr[i] = '0; m_qj[i] = '0; m_qk[i] = '0;
    end
    m_order.delete();
  endtask

  task automatic apply(input stim_t s);
    bus.issue_valid  = s.issue_valid;
    bus.issue_op     = s.op;
    bus.issue_vj     = s.vj;
    bus.issue_vk     = s.vk;
    bus.issue_addr   = s.addr;
    bus.issue_qj     = s.qj;
    bus.issue_qk     = s.qk;
    bus.cdb_valid    = s.cdb_valid;
    bus.cdb_tag      = s.cdb_tag;
    bus.cdb_data     = s.cdb_data;
    bus.dispatch_ack = s.ack;
    bus.clear_valid  = s.clear_valid;
    bus.clear_tag    = s.clear_tag;
    bus.flush        = s.flush;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    apply(idle_s());
    model_reset();
  endtask

  // driver: apply one cycle of stimulus, predict this cycle's outputs, advance the model
  task automatic drive_cycle(input stim_t s);
    int      fidx;
    int      didx;
    int      e;
    logic    chit;
    logic    rdy;
    status_t st;
    @(negedge clk);
    rst_n = 1'b1;
    apply(s);
    chit = s.cdb_valid && (s.cdb_tag != '0);
    fidx = -1;
    for (int i = NE - 1; i >= 0; i--) if (!m_busy[i]) fidx = i;
    didx = -1;
    for (int k = 0; k < m_order.size(); k++) begin
      e = m_order[k];
      if (didx < 0 && !m_disp[e] && m_qj[e] == '0 && m_qk[e] == '0) didx = e;
    end
    rdy = (fidx >= 0);
`ifndef TOMASULO_RS_ISSUE_BYPASS_EN
    if (chit && (s.qj == s.cdb_tag || s.qk == s.cdb_tag)) rdy = 1'b0;
`endif
    st = '0;
    st.ready    = rdy;
    st.has_free = (fidx >= 0);
    st.tag      = (fidx >= 0) ? TW'(BASE + fidx) : '0;
    for (int i = 0; i < NE; i++) begin
      if (m_busy[i]) begin
        st.occ     = st.occ + OW'(1);
        st.busy[i] = 1'b1;
      end
    end
    st.dv  = (didx >= 0);
    st.pkt = (didx >= 0) ? pkt_of(didx) : '0;
    stat_q.push_back(st);
    if (didx >= 0 && s.ack) exp_q.push_back(pkt_of(didx));

    if (s.flush) begin
      model_reset();
    end else begin
      // clear only affects an entry that was already executing before this cycle
      if (s.clear_valid) begin
        e = int'(s.clear_tag) - BASE;
        if (e >= 0 && e < NE && m_busy[e] && m_disp[e]) begin
          m_busy[e] = 1'b0;
          m_disp[e] = 1'b0;
          for (int k = m_order.size() - 1; k >= 0; k--) if (m_order[k] == e) m_order.delete(k);
        end
      end
      if (chit) begin
        for (int i = 0; i < NE; i++) begin
          if (m_busy[i] && !m_disp[i]) begin
            if (m_qj[i] == s.cdb_tag) begin m_vj[i] = s.cdb_data; m_qj[i] = '0; end
            if (m_qk[i] == s.cdb_tag) begin m_vk[i] = s.cdb_data; m_qk[i] = '0; end
          end
        end
      end
      if (didx >= 0 && s.ack) m_disp[didx] = 1'b1;
      if (s.issue_valid && rdy) begin
        m_busy[fidx] = 1'b1; m_disp[fidx] = 1'b0;
        m_op[fidx] = s.op; m_addr[fidx] = s.addr;
        m_vj[fidx] = s.vj; m_qj[fidx] = s.qj;
        m_vk[fidx] = s.vk; m_qk[fidx] = s.qk;
`ifdef TOMASULO_RS_ISSUE_BYPASS_EN
        if (chit && s.qj == s.cdb_tag) begin m_vj[fidx] = s.cdb_data; m_qj[fidx] = '0; end
        if (chit && s.qk == s.cdb_tag) begin m_vk[fidx] = s.cdb_data; m_qk[fidx] = '0; end
`endif
        m_order.push_back(fidx);
      end
    end
  endtask

  task automatic issue_c(input logic [2:0] op, input logic [DW-1:0] vj, input logic [DW-1:0] vk,
                         input logic [TW-1:0] qj, input logic [TW-1:0] qk);
    stim_t s;
    s = idle_s();
    s.issue_valid = 1'b1; s.op = op; s.vj = vj; s.vk = vk; s.qj = qj; s.qk = qk;
    s.addr = $urandom();
    drive_cycle(s);
  endtask

  task automatic cdb_c(input logic [TW-1:0] tag, input logic [DW-1:0] data);
    stim_t s;
    s = idle_s();
    s.cdb_valid = 1'b1; s.cdb_tag = tag; s.cdb_data = data;
    drive_cycle(s);
  endtask

  task automatic ack_c();
    stim_t s;
    s = idle_s();
    s.ack = 1'b1;
    drive_cycle(s);
  endtask

  task automatic clear_c(input logic [TW-1:0] tag);
    stim_t s;
    s = idle_s();
    s.clear_valid = 1'b1; s.clear_tag = tag;
    drive_cycle(s);
  endtask

  task automatic idle_c(input int n);
    for (int i = 0; i < n; i++) drive_cycle(idle_s());
  endtask

  function automatic stim_t rand_s();
    stim_t s;
    int    ex[$];
    s = '0;
    s.issue_valid = ($urandom_range(0, 1) == 1);
    s.op   = 3'($urandom_range(0, 7));
    s.vj   = $urandom();
    s.vk   = $urandom();
    s.addr = $urandom();
    s.qj   = ($urandom_range(0, 2) == 0) ? TW'($urandom_range(1, 7)) : '0;
    s.qk   = ($urandom_range(0, 2) == 0) ? TW'($urandom_range(1, 7)) : '0;
    s.cdb_valid = ($urandom_range(0, 9) < 4);
    s.cdb_tag   = TW'($urandom_range(0, 7));
    s.cdb_data  = $urandom();
    s.ack       = ($urandom_range(0, 9) < 6);
    s.clear_valid = ($urandom_range(0, 9) < 4);
    for (int i = 0; i < NE; i++) if (m_busy[i] && m_disp[i]) ex.push_back(i);
    if (ex.size() > 0 && $urandom_range(0, 3) != 0)
      s.clear_tag = TW'(BASE + ex[$urandom_range(0, ex.size() - 1)]);
    else
      s.clear_tag = TW'($urandom_range(0, 7));
    s.flush = ($urandom_range(0, 63) == 0);
    return s;
  endfunction

  // monitor: compare the current cycle's outputs away from the rising edge
  initial begin
    status_t       st;
    logic [PW-1:0] act;
    logic [NE-1:0] act_busy;
    forever begin
      @(negedge clk);
      #2;
      act = {bus.dispatch_op, bus.dispatch_vj, bus.dispatch_vk, bus.dispatch_addr, bus.dispatch_tag};
      if (stat_q.size() > 0) begin
        st = stat_q.pop_front();
        for (int i = 0; i < NE; i++) act_busy[i] = (state_dbg[2*i +: 2] != 2'd0);
        check("issue_ready", PW'(bus.issue_ready), PW'(st.ready));
        if (st.has_free) check("issue_tag", PW'(bus.issue_tag), PW'(st.tag));
        check("occupancy", PW'(bus.occupancy), PW'(st.occ));
        check("dispatch_valid", PW'(bus.dispatch_valid), PW'(st.dv));
        check("dispatch_fields", act, st.pkt);
        check("busy_entries", PW'(act_busy), PW'(st.busy));
      end
      if (rst_n && bus.dispatch_valid && bus.dispatch_ack) begin
        if (exp_q.size() == 0) begin
          check("dispatch_unexpected", act, '0);
        end else begin
          check("dispatch_xfer", act, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    stim_t s;
    apply(idle_s());
    model_reset();
    do_reset();
    do_reset();

    // single ready instruction dispatches the cycle after issue
    issue_c(3'd1, 32'd5, 32'd7, '0, '0);
    idle_c(1);
    ack_c();
    clear_c(4'd1);

    // wakeup by CDB, visible for dispatch one cycle later
    issue_c(3'd2, 32'd0, 32'd9, 4'd3, '0);
    idle_c(1);
    cdb_c(4'd3, 32'hAA);
    idle_c(1);
    ack_c();
    clear_c(4'd1);

    // full array, then free tag 2 and expect it reallocated
    do_reset();
    for (int i = 0; i < NE; i++) issue_c(3'(i), $urandom(), $urandom(), '0, '0);
    idle_c(1);
    for (int i = 0; i < NE; i++) ack_c();
    clear_c(4'd2);
    idle_c(1);

    // age order: entry 3 issued before entry 1, both woken, 3 goes first
    do_reset();
    issue_c(3'd1, 32'd1, 32'd1, '0, '0);
    issue_c(3'd2, 32'd2, 32'd2, '0, '0);
    issue_c(3'd3, 32'd3, 32'd3, 4'd6, '0);
    ack_c();
    ack_c();
    clear_c(4'd1);
    issue_c(3'd4, 32'd4, 32'd4, 4'd7, '0);
    cdb_c(4'd7, 32'h70);
    cdb_c(4'd6, 32'h60);
    idle_c(1);
    ack_c();
    ack_c();

    // issue operand tag matches a same-cycle broadcast
    do_reset();
    s = idle_s();
    s.issue_valid = 1'b1; s.op = 3'd5; s.vj = 32'h1; s.vk = 32'h2; s.qj = 4'd5;
    s.cdb_valid = 1'b1; s.cdb_tag = 4'd5; s.cdb_data = 32'h11;
    drive_cycle(s);
    idle_c(1);
    ack_c();

    // flush with three busy entries and a concurrent issue
    do_reset();
    issue_c(3'd1, 32'd10, 32'd11, '0, '0);
    issue_c(3'd2, 32'd12, 32'd13, 4'd2, '0);
    issue_c(3'd3, 32'd14, 32'd15, '0, 4'd4);
    s = idle_s();
    s.flush = 1'b1; s.issue_valid = 1'b1; s.op = 3'd6; s.ack = 1'b1;
    s.cdb_valid = 1'b1; s.cdb_tag = 4'd2; s.clear_valid = 1'b1; s.clear_tag = 4'd1;
    drive_cycle(s);
    idle_c(2);

    // randomized traffic with a reset in the middle
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) do_reset();
      drive_cycle(rand_s());
    end
    idle_c(2);
    @(negedge clk);
    #3;
    check("scoreboard_drained", PW'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
